// File: rtl/team_06_pkg.sv
// -----------------------------------------------------------------------------
// team_06_pkg
// Shared definitions for the audio gate block:
//   - gate_state_t  : noise gate FSM states (CLOSED / OPEN / HOLD)
//   - default GATE_THRESH / HOLD_SAMPLES values
//   - datapath widths used by the scaling pipeline
//   - abs_level()   : 9-bit magnitude of a signed 8-bit sample
// -----------------------------------------------------------------------------
package team_06_pkg;

   typedef enum logic [1:0] {
      GATE_CLOSED = 2'd0,
      GATE_OPEN   = 2'd1,
      GATE_HOLD   = 2'd2
   } gate_state_t;

   localparam int DEFAULT_GATE_THRESH  = 8;
   localparam int DEFAULT_HOLD_SAMPLES = 1024;

   localparam int SAMPLE_W   = 8;    // signed audio sample
   localparam int LEVEL_W    = 9;    // |sample|, wide enough to hold 128
   localparam int VOLUME_W   = 4;    // gain step 0..15
   localparam int PROD_W     = 12;   // sample * volume, signed
   localparam int HOLD_CNT_W = 16;   // hold counter, up to 65535

   // Magnitude in 9 bits so that -128 maps to +128 instead of wrapping.
   function automatic logic [LEVEL_W-1:0] abs_level(input logic [SAMPLE_W-1:0] s);
      logic [LEVEL_W-1:0] ext;
      ext = {s[SAMPLE_W-1], s};
      if (s[SAMPLE_W-1]) begin
         abs_level = ~ext + 9'd1;
      end else begin
         abs_level = ext;
      end
   endfunction

endpackage

// File: rtl/team_06_noise_gate_fsm.sv
// -----------------------------------------------------------------------------
// team_06_noise_gate_fsm
// Noise gate state machine with its hold counter. The state only moves on a
// valid sample. A loud sample (or a disabled gate) opens the gate and reloads
// the hold counter; quiet samples walk OPEN -> HOLD -> CLOSED as the counter
// runs out.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset (state CLOSED, count 0)
//   sample_valid in   strobe qualifying level/noise_gate
//   level        in   |sample| (9 bits)
//   noise_gate   in   gate enable; 0 forces OPEN on every valid sample
//   open_next    out  1 when the state after this cycle's transition is not
//                     CLOSED (used to pass/block the current sample)
//   gate_open    out  1 when the registered state is not CLOSED
// -----------------------------------------------------------------------------
module team_06_noise_gate_fsm
   import team_06_pkg::*;
#(
   parameter int GATE_THRESH  = DEFAULT_GATE_THRESH,
   parameter int HOLD_SAMPLES = DEFAULT_HOLD_SAMPLES
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sample_valid,
   input  logic [LEVEL_W-1:0] level,
   input  logic               noise_gate,
   output logic               open_next,
   output logic               gate_open
);

   localparam logic [LEVEL_W-1:0]    THRESH_L = LEVEL_W'(GATE_THRESH);
   localparam logic [HOLD_CNT_W-1:0] HOLD_L   = HOLD_CNT_W'(HOLD_SAMPLES);

   gate_state_t             state_reg;
   gate_state_t             state_next;
   logic [HOLD_CNT_W-1:0]   hold_cnt_reg;
   logic [HOLD_CNT_W-1:0]   hold_cnt_next;
   logic                    loud;

   assign loud = (level >= THRESH_L);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= GATE_CLOSED;
         hold_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         hold_cnt_reg <= hold_cnt_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next    = state_reg;
      hold_cnt_next = hold_cnt_reg;
      if (sample_valid) begin
         if (!noise_gate || loud) begin
            state_next    = GATE_OPEN;
            hold_cnt_next = HOLD_L;
         end else begin
            case (state_reg)
               GATE_OPEN: begin
                  state_next    = GATE_HOLD;
                  hold_cnt_next = hold_cnt_reg - 16'd1;
               end
               GATE_HOLD: begin
                  // A count of 1 decrements to 0, which closes the gate. A
                  // count already at 0 (HOLD_SAMPLES=1) also closes here.
                  if (hold_cnt_reg <= 16'd1) begin
                     state_next    = GATE_CLOSED;
                     hold_cnt_next = '0;
                  end else begin
                     hold_cnt_next = hold_cnt_reg - 16'd1;
                  end
               end
               default: begin
                  state_next    = GATE_CLOSED;
                  hold_cnt_next = '0;
               end
            endcase
         end
      end
   end

   // Outputs
   always_comb begin
      gate_open = (state_reg != GATE_CLOSED);
      open_next = (state_next != GATE_CLOSED);
   end

endmodule

// File: rtl/team_06_audio_gate.sv
// -----------------------------------------------------------------------------
// team_06_audio_gate
// Two-stage audio path: noise gate, mute / push-to-talk blocking and a 4-bit
// volume scaler. Every valid input sample yields exactly one out_valid pulse
// two cycles later; blocked samples come out as 0.
//
// Stage 1 (on sample_valid): capture sample and volume, advance the gate FSM,
//          and latch the pass/block decision from the post-transition state
//          together with mute and ptt.
// Stage 2: scale the captured sample, (sample * volume) >>> 4, or emit 0 when
//          blocked; sample_out holds between pulses.
//
// Ports:
//   clk          in   system clock (25 MHz)
//   rst          in   asynchronous active-high reset, flushes the pipeline
//   sample_in    in   signed 8-bit audio sample
//   sample_valid in   1-cycle strobe for sample_in (back-to-back allowed)
//   volume       in   gain step 0..15
//   ptt          in   push-to-talk level
//   noise_gate   in   noise gate enable
//   mute         in   mute enable
//   sample_out   out  signed 8-bit processed sample
//   out_valid    out  1-cycle strobe for sample_out
//   gate_open    out  1 when the gate is not CLOSED
// -----------------------------------------------------------------------------
module team_06_audio_gate
   import team_06_pkg::*;
#(
   parameter int GATE_THRESH  = DEFAULT_GATE_THRESH,
   parameter int HOLD_SAMPLES = DEFAULT_HOLD_SAMPLES,
   parameter int PTT_REQUIRED = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic signed [SAMPLE_W-1:0] sample_in,
   input  logic                       sample_valid,
   input  logic [VOLUME_W-1:0]        volume,
   input  logic                       ptt,
   input  logic                       noise_gate,
   input  logic                       mute,
   output logic signed [SAMPLE_W-1:0] sample_out,
   output logic                       out_valid,
   output logic                       gate_open
);

   // ---------------------------------------------------------------------
   // Gate FSM
   // ---------------------------------------------------------------------
   logic [LEVEL_W-1:0] level;
   logic               open_next;

   assign level = abs_level(sample_in);

   team_06_noise_gate_fsm #(
      .GATE_THRESH  (GATE_THRESH),
      .HOLD_SAMPLES (HOLD_SAMPLES)
   ) u_gate_fsm (
      .clk          (clk),
      .rst          (rst),
      .sample_valid (sample_valid),
      .level        (level),
      .noise_gate   (noise_gate),
      .open_next    (open_next),
      .gate_open    (gate_open)
   );

   // ---------------------------------------------------------------------
   // Stage 1: capture sample, volume and the pass decision
   // ---------------------------------------------------------------------
   logic                s1_valid_reg;
   logic [SAMPLE_W-1:0] s1_sample_reg;
   logic [VOLUME_W-1:0] s1_volume_reg;
   logic                s1_pass_reg;
   logic                pass_next;

   // Controls only matter in the cycle they are captured alongside the sample.
   assign pass_next = !mute && open_next && ((PTT_REQUIRED == 0) || ptt);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_reg  <= 1'b0;
         s1_sample_reg <= '0;
         s1_volume_reg <= '0;
         s1_pass_reg   <= 1'b0;
      end else begin
         s1_valid_reg <= sample_valid;
         if (sample_valid) begin
            s1_sample_reg <= sample_in;
            s1_volume_reg <= volume;
            s1_pass_reg   <= pass_next;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stage 2 datapath: shift-and-add multiply by the 4-bit volume.
   // The sample is sign-extended to 12 bits; modulo-2^12 addition of the
   // partial products gives the exact signed product (range -1920..1905).
   // ---------------------------------------------------------------------
   logic [PROD_W-1:0]   sample_ext;
   logic [PROD_W-1:0]   pp [VOLUME_W];
   logic [PROD_W-1:0]   prod;
   logic [SAMPLE_W-1:0] scaled;

   assign sample_ext = {{(PROD_W-SAMPLE_W){s1_sample_reg[SAMPLE_W-1]}}, s1_sample_reg};

   for (genvar gi = 0; gi < VOLUME_W; gi++) begin : g_pp
      assign pp[gi] = s1_volume_reg[gi] ? (sample_ext << gi) : '0;
   end

   always_comb begin
      prod = '0;
      for (int i = 0; i < VOLUME_W; i++) begin
         prod = prod + pp[i];
      end
   end

   // Arithmetic shift floors toward -inf; the result always fits in 8 bits.
   assign scaled = SAMPLE_W'($signed(prod) >>> 4);

   // ---------------------------------------------------------------------
   // Stage 2 registers
   // ---------------------------------------------------------------------
   logic                out_valid_reg;
   logic [SAMPLE_W-1:0] sample_out_reg;
   logic [SAMPLE_W-1:0] sample_out_next;

   always_comb begin
      sample_out_next = sample_out_reg;
      if (s1_valid_reg) begin
         sample_out_next = s1_pass_reg ? scaled : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_reg  <= 1'b0;
         sample_out_reg <= '0;
      end else begin
         out_valid_reg  <= s1_valid_reg;
         sample_out_reg <= sample_out_next;
      end
   end

   assign out_valid  = out_valid_reg;
   assign sample_out = sample_out_reg;

endmodule

// File: tb/tb_team_06_audio_gate.sv
// -----------------------------------------------------------------------------
// tb_team_06_audio_gate
// Directed bench for team_06_audio_gate (GATE_THRESH=8, HOLD_SAMPLES=4,
// PTT_REQUIRED=1). Inputs change on the falling edge, outputs are read on the
// falling edge. After each valid strobe the controls and sample are inverted
// so that any late sampling of them shows up in the result.
// -----------------------------------------------------------------------------
module tb_team_06_audio_gate;

   logic              clk;
   logic              rst;
   logic signed [7:0] sample_in;
   logic              sample_valid;
   logic [3:0]        volume;
   logic              ptt;
   logic              noise_gate;
   logic              mute;
   logic signed [7:0] sample_out;
   logic              out_valid;
   logic              gate_open;

   int n_checks;
   int n_fail;

   team_06_audio_gate #(
      .GATE_THRESH  (8),
      .HOLD_SAMPLES (4),
      .PTT_REQUIRED (1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .volume       (volume),
      .ptt          (ptt),
      .noise_gate   (noise_gate),
      .mute         (mute),
      .sample_out   (sample_out),
      .out_valid    (out_valid),
      .gate_open    (gate_open)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // One valid strobe, then inverted controls/sample while idle.
   task automatic send(input int s, input int vol, input bit p, input bit ng, input bit m);
      @(negedge clk);
      sample_in    = 8'(s);
      volume       = 4'(vol);
      ptt          = p;
      noise_gate   = ng;
      mute         = m;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      sample_in    = ~sample_in;
      volume       = ~volume;
      ptt          = ~ptt;
      noise_gate   = ~noise_gate;
      mute         = ~mute;
   endtask

   // Full transaction: send, then check gate state, latency, data and hold.
   task automatic txn(input string tag, input int s, input int vol, input bit p,
                      input bit ng, input bit m, input int exp, input bit exp_gate);
      send(s, vol, p, ng, m);
      check_val({tag, ".gate"},  int'(gate_open), int'(exp_gate));
      check_val({tag, ".early"}, int'(out_valid), 0);
      @(negedge clk);
      check_val({tag, ".valid"}, int'(out_valid), 1);
      check_val({tag, ".data"},  int'(sample_out), exp);
      $display("txn %s: in=%0d vol=%0d ptt=%0d ng=%0d mute=%0d -> out=%0d gate=%0d",
               tag, s, vol, p, ng, m, sample_out, gate_open);
      @(negedge clk);
      check_val({tag, ".single"}, int'(out_valid), 0);
      check_val({tag, ".hold"},   int'(sample_out), exp);
   endtask

   // Back-to-back vectors at volume 15, outputs hand computed as floor(s*15/16).
   int b2b_in  [10] = '{100, -100, 1, -1, 16, -16, 127, -128, 50, -50};
   int b2b_exp [10] = '{ 93,  -94, 0, -1, 15, -15, 119, -120, 46, -47};

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      rst          = 1'b1;
      sample_in    = '0;
      sample_valid = 1'b0;
      volume       = '0;
      ptt          = 1'b0;
      noise_gate   = 1'b0;
      mute         = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check_val("rst.sample_out", int'(sample_out), 0);
      check_val("rst.out_valid",  int'(out_valid), 0);
      check_val("rst.gate_open",  int'(gate_open), 0);
      rst = 1'b0;

      // Scaling and latency, gate disabled
      txn("lat100",   100,  8, 1, 0, 0,   50, 1);
      txn("neg128",  -128, 15, 1, 0, 0, -120, 1);
      txn("neg1",      -1, 15, 1, 0, 0,   -1, 1);
      txn("vol0",     100,  0, 1, 0, 0,    0, 1);
      txn("pos127",   127, 15, 1, 0, 0,  119, 1);

      // Gate open and hold (HOLD_SAMPLES=4)
      txn("g20",       20, 15, 1, 1, 0,   18, 1);
      txn("g0a",        0, 15, 1, 1, 0,    0, 1);
      txn("g0b",        0, 15, 1, 1, 0,    0, 1);
      txn("g0c",        0, 15, 1, 1, 0,    0, 1);
      txn("g0d",        0, 15, 1, 1, 0,    0, 0);
      txn("g0e",        0, 15, 1, 1, 0,    0, 0);
      // Threshold boundary and close on a nonzero quiet sample
      txn("quiet7",     7, 15, 1, 1, 0,    0, 0);
      txn("thresh8",    8, 15, 1, 1, 0,    7, 1);
      txn("hold7",      7, 15, 1, 1, 0,    6, 1);
      txn("reopen",    -8, 15, 1, 1, 0,   -8, 1);
      txn("holda",     -7, 15, 1, 1, 0,   -7, 1);
      txn("holdb",      3, 15, 1, 1, 0,    2, 1);
      txn("holdc",      3, 15, 1, 1, 0,    2, 1);
      txn("close",      3, 15, 1, 1, 0,    0, 0);
      txn("abs128",  -128, 15, 1, 1, 0, -120, 1);

      // Mute / ptt blocking
      txn("m_pre",     64, 15, 1, 0, 0,   60, 1);
      txn("mute",      64, 15, 1, 0, 1,    0, 1);
      txn("p_pre",     64, 15, 1, 0, 0,   60, 1);
      txn("ptt0",      64, 15, 0, 0, 0,    0, 1);
      txn("ptt1",      64, 15, 1, 0, 0,   60, 1);

      // Control sampling: volume flips to 0 right after the strobe
      txn("ctl",       32, 15, 1, 0, 0,   30, 1);

      // Back-to-back throughput
      volume     = 4'd15;
      ptt        = 1'b1;
      noise_gate = 1'b0;
      mute       = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i < 10) begin
            sample_in    = 8'(b2b_in[i]);
            sample_valid = 1'b1;
         end else begin
            sample_valid = 1'b0;
         end
         if (i >= 2) begin
            check_val($sformatf("b2b%0d.valid", i - 2), int'(out_valid), 1);
            check_val($sformatf("b2b%0d.data", i - 2), int'(sample_out), b2b_exp[i - 2]);
            $display("txn b2b%0d: in=%0d -> out=%0d", i - 2, b2b_in[i - 2], sample_out);
         end else begin
            check_val($sformatf("b2b_pre%0d.valid", i), int'(out_valid), 0);
         end
      end
      @(negedge clk);
      check_val("b2b.end_valid", int'(out_valid), 0);

      // Reset one cycle after a strobe: sample must vanish
      @(negedge clk);
      sample_in    = 8'sd100;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      rst          = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_val("rstmid.valid0",  int'(out_valid), 0);
      check_val("rstmid.data",    int'(sample_out), 0);
      check_val("rstmid.gate",    int'(gate_open), 0);
      @(negedge clk);
      check_val("rstmid.valid1",  int'(out_valid), 0);
      @(negedge clk);
      check_val("rstmid.valid2",  int'(out_valid), 0);
      $display("txn rstmid: in=100 -> out=%0d valid=%0d gate=%0d", sample_out, out_valid, gate_open);

      // Sample in the first cycle after reset deasserts
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst          = 1'b0;
      sample_in    = 8'sd16;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      check_val("rstfirst.gate",  int'(gate_open), 1);
      check_val("rstfirst.early", int'(out_valid), 0);
      @(negedge clk);
      check_val("rstfirst.valid", int'(out_valid), 1);
      check_val("rstfirst.data",  int'(sample_out), 15);
      $display("txn rstfirst: in=16 -> out=%0d", sample_out);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Guard against a stuck run.
   initial begin
      #1ms;
      $display("FAIL timeout: got no finish, expected finish within 1 ms");
      $fatal(1, "timeout");
   end

endmodule
